// File: rtl/hdma_controller.sv
// GBC VRAM DMA engine (HDMA1-HDMA5): copies 16-byte blocks from the router bus into VRAM,
// either all at once (GDMA) or one block per HBlank (HDMA), while stalling the CPU.
module hdma_controller #(
  parameter int READ_LATENCY = 1
) (
  input  logic        I_CLK,
  input  logic        I_RESET_L,
  input  logic [15:0] I_IOREG_ADDR,
  inout  wire  [7:0]  IO_IOREG_DATA,
  input  logic        I_IOREG_WE_L,
  input  logic        I_IOREG_RE_L,
  input  logic        I_IN_DMG_MODE,
  input  logic        I_HBLANK,
  output logic        O_BUS_REQ,
  input  logic        I_BUS_GNT,
  output logic        O_CPU_STALL,
  output logic [15:0] O_MEM_ADDR,
  output logic [7:0]  O_MEM_DATA,
  input  logic [7:0]  I_MEM_DATA,
  output logic        O_MEM_RE_L,
  output logic        O_MEM_WE_L
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_WAIT_HB, ST_REQ, ST_RD, ST_WR, ST_NEXT
  } state_t;

  localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY);

  state_t      state_r, state_s;
  logic [15:0] src_r, src_s;
  logic [12:0] dst_r, dst_s;
  logic [6:0]  len_r, len_s;
  logic        active_r, active_s;
  logic        hdma_r, hdma_s;
  logic [1:0]  cnt_r, cnt_s;
  logic [3:0]  bcnt_r, bcnt_s;
  logic [7:0]  data_r, data_s;
  logic        hblank_prev_r;
  logic        reg_we_s, busy_s, re_s, we_s, rd_hit_s;
  logic [15:0] addr_s;
  logic [7:0]  wdata_s, rd_data_s;

  // IO read mux: the registers are write-only except the FF55 status byte
  always_comb begin
    rd_hit_s = !I_IOREG_RE_L && (I_IOREG_ADDR >= 16'hFF51) && (I_IOREG_ADDR <= 16'hFF55);
    if (I_IN_DMG_MODE || (I_IOREG_ADDR != 16'hFF55)) begin
      rd_data_s = 8'hFF;
    end else begin
      rd_data_s = {~active_r, len_r};
    end
  end

  assign IO_IOREG_DATA = rd_hit_s ? rd_data_s : 8'hzz;

  // Next-state, datapath updates and register writes
  always_comb begin
    state_s  = state_r;
    src_s    = src_r;
    dst_s    = dst_r;
    len_s    = len_r;
    active_s = active_r;
    hdma_s   = hdma_r;
    cnt_s    = cnt_r;
    bcnt_s   = bcnt_r;
    data_s   = data_r;
    reg_we_s = !I_IOREG_WE_L && !I_IN_DMG_MODE &&
               ((state_r == ST_IDLE) || (state_r == ST_WAIT_HB));

    case (state_r)
      ST_IDLE: state_s = ST_IDLE;
      ST_WAIT_HB: begin
        if (I_HBLANK && !hblank_prev_r) state_s = ST_REQ;
        else                            state_s = ST_WAIT_HB;
      end
      ST_REQ: begin
        if (I_BUS_GNT) begin
          state_s = ST_RD;
          cnt_s   = 2'd0;
          bcnt_s  = 4'd0;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_RD: begin
        if (cnt_r == LAT_LAST) begin
          data_s  = I_MEM_DATA;
          state_s = ST_WR;
        end else begin
          cnt_s = cnt_r + 2'd1;
        end
      end
      ST_WR: begin
        src_s  = src_r + 16'd1;
        dst_s  = dst_r + 13'd1;
        bcnt_s = bcnt_r + 4'd1;
        cnt_s  = 2'd0;
        if (bcnt_r == 4'd15) state_s = ST_NEXT;
        else                 state_s = ST_RD;
      end
      ST_NEXT: begin
        if (len_r == 7'd0) begin
          len_s    = 7'h7F;
          active_s = 1'b0;
          state_s  = ST_IDLE;
        end else begin
          len_s   = len_r - 7'd1;
          state_s = hdma_r ? ST_WAIT_HB : ST_RD;
        end
      end
      default: state_s = ST_IDLE;
    endcase

    // A stop write overrides a same-cycle HBlank rise, so it is applied last
    if (reg_we_s) begin
      case (I_IOREG_ADDR)
        16'hFF51: src_s[15:8] = IO_IOREG_DATA;
        16'hFF52: src_s[7:0]  = {IO_IOREG_DATA[7:4], 4'h0};
        16'hFF53: dst_s[12:8] = IO_IOREG_DATA[4:0];
        16'hFF54: dst_s[7:0]  = {IO_IOREG_DATA[7:4], 4'h0};
        16'hFF55: begin
          if (!active_r) begin
            len_s    = IO_IOREG_DATA[6:0];
            active_s = 1'b1;
            hdma_s   = IO_IOREG_DATA[7];
            state_s  = IO_IOREG_DATA[7] ? ST_WAIT_HB : ST_REQ;
          end else if ((state_r == ST_WAIT_HB) && !IO_IOREG_DATA[7]) begin
            active_s = 1'b0;
            state_s  = ST_IDLE;
          end else begin
            active_s = active_r;
          end
        end
        default: src_s = src_s;
      endcase
    end else begin
      src_s = src_s;
    end
  end

  // Bus outputs decoded from the next state so the registered pins line up with the state
  always_comb begin
    busy_s  = (state_s == ST_REQ) || (state_s == ST_RD) ||
              (state_s == ST_WR)  || (state_s == ST_NEXT);
    re_s    = (state_s == ST_RD);
    we_s    = (state_s == ST_WR);
    wdata_s = 8'h00;
    if (re_s) begin
      addr_s = src_s;
    end else if (we_s) begin
      addr_s  = {3'b100, dst_s};
      wdata_s = data_s;
    end else begin
      addr_s = 16'h0000;
    end
  end

  // State, datapath and output registers with synchronous reset
  always_ff @(posedge I_CLK) begin
    if (!I_RESET_L) begin
      state_r       <= ST_IDLE;
      src_r         <= 16'h0000;
      dst_r         <= 13'h0000;
      len_r         <= 7'h7F;
      active_r      <= 1'b0;
      hdma_r        <= 1'b0;
      cnt_r         <= 2'd0;
      bcnt_r        <= 4'd0;
      data_r        <= 8'h00;
      hblank_prev_r <= 1'b0;
      O_BUS_REQ     <= 1'b0;
      O_CPU_STALL   <= 1'b0;
      O_MEM_ADDR    <= 16'h0000;
      O_MEM_DATA    <= 8'h00;
      O_MEM_RE_L    <= 1'b1;
      O_MEM_WE_L    <= 1'b1;
    end else begin
      state_r       <= state_s;
      src_r         <= src_s;
      dst_r         <= dst_s;
      len_r         <= len_s;
      active_r      <= active_s;
      hdma_r        <= hdma_s;
      cnt_r         <= cnt_s;
      bcnt_r        <= bcnt_s;
      data_r        <= data_s;
      hblank_prev_r <= I_HBLANK;
      O_BUS_REQ     <= busy_s;
      O_CPU_STALL   <= busy_s;
      O_MEM_ADDR    <= addr_s;
      O_MEM_DATA    <= wdata_s;
      O_MEM_RE_L    <= !re_s;
      O_MEM_WE_L    <= !we_s;
    end
  end

endmodule

// File: tb/tb_hdma_controller.sv
// Scoreboard bench for hdma_controller: expected byte copies are queued from a flat
// address model and matched by a monitor watching the memory strobes.
module tb_hdma_controller;
  localparam int RL = 1;
  localparam int BLK_CYC = 16 * (RL + 2);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_l, io_we_l, io_re_l, dmg, hblank, gnt_tied, io_oe;
  logic        gnt_r = 1'b0;
  logic [15:0] io_addr;
  logic [7:0]  io_wdata;
  wire  [7:0]  io_data;
  logic        bus_req, stall, mem_re_l, mem_we_l, gnt;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic [7:0]  mem [0:65535];
  int          re_cnt = 0, gcnt = 0, gnt_delay = 0;
  int          n_checks = 0, n_errors = 0, re_run = 0, stall_cycles = 0;
  logic        mon_en = 1'b0;

  typedef struct {
    logic [15:0] src;
    logic [15:0] dst;
    logic [7:0]  data;
  } xfer_t;
  xfer_t q[$];

  assign io_data = io_oe ? io_wdata : 8'hzz;
  assign gnt = gnt_tied | gnt_r;

  // Source memory: valid data only once the strobe has been low for RL edges
  always @(posedge clk) re_cnt <= mem_re_l ? 0 : re_cnt + 1;
  assign mem_rdata = (!mem_re_l && re_cnt == RL) ? mem[mem_addr] : ~mem[mem_addr];

  // Arbiter: grants gnt_delay cycles after a request and holds while requested
  always @(posedge clk) begin
    if (!bus_req) begin
      gnt_r <= 1'b0;
      gcnt  <= 0;
    end else if (gcnt >= gnt_delay) begin
      gnt_r <= 1'b1;
    end else begin
      gcnt <= gcnt + 1;
    end
  end

  hdma_controller #(.READ_LATENCY(RL)) dut (
    .I_CLK(clk), .I_RESET_L(rst_l), .I_IOREG_ADDR(io_addr), .IO_IOREG_DATA(io_data),
    .I_IOREG_WE_L(io_we_l), .I_IOREG_RE_L(io_re_l), .I_IN_DMG_MODE(dmg), .I_HBLANK(hblank),
    .O_BUS_REQ(bus_req), .I_BUS_GNT(gnt), .O_CPU_STALL(stall), .O_MEM_ADDR(mem_addr),
    .O_MEM_DATA(mem_wdata), .I_MEM_DATA(mem_rdata), .O_MEM_RE_L(mem_re_l), .O_MEM_WE_L(mem_we_l)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected copies for nblk blocks starting at src / VRAM offset dst13
  task automatic push_blocks(input logic [15:0] src, input logic [12:0] dst13, input int nblk);
    xfer_t e;
    for (int k = 0; k < nblk * 16; k++) begin
      e.src  = src + 16'(k);
      e.dst  = {3'b100, dst13 + 13'(k)};
      e.data = mem[e.src];
      q.push_back(e);
    end
  endtask

  // Monitor: pops the scoreboard on every VRAM write and checks read addresses
  always @(negedge clk) begin
    if (mon_en) begin
      if (stall) stall_cycles++;
      if (!mem_re_l || !mem_we_l) begin
        check("strobe_without_grant", {31'd0, gnt}, 32'd1);
        check("strobes_overlap", {31'd0, mem_re_l | mem_we_l}, 32'd1);
        check("unexpected_bus_access", {31'd0, q.size() != 0}, 32'd1);
      end
      if (!mem_re_l) begin
        re_run++;
        if (q.size() != 0) check("read_addr", {16'd0, mem_addr}, {16'd0, q[0].src});
      end
      if (!mem_we_l && q.size() != 0) begin
        xfer_t e;
        e = q.pop_front();
        check("write_addr", {16'd0, mem_addr}, {16'd0, e.dst});
        check("write_data", {24'd0, mem_wdata}, {24'd0, e.data});
        check("read_cycles", re_run, RL + 1);
      end
      if (mem_re_l) re_run = 0;
    end
  end

  task automatic io_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    io_addr = a; io_wdata = d; io_oe = 1'b1; io_we_l = 1'b0;
    @(negedge clk);
    io_we_l = 1'b1; io_oe = 1'b0;
  endtask

  task automatic io_read_check(input string name, input logic [15:0] a, input logic [7:0] exp);
    @(negedge clk);
    io_addr = a; io_re_l = 1'b0;
    #1;
    check(name, {24'd0, io_data}, {24'd0, exp});
    io_re_l = 1'b1;
  endtask

  task automatic set_regs(input logic [15:0] src, input logic [12:0] dst13);
    logic [7:0] junk;
    junk = 8'($urandom);
    io_write(16'hFF51, src[15:8]);
    io_write(16'hFF52, {src[7:4], junk[3:0]});
    io_write(16'hFF53, {junk[7:5], dst13[12:8]});
    io_write(16'hFF54, {dst13[7:4], junk[3:0]});
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!(q.size() == 0 && !bus_req) && n < budget);
    check(name, {31'd0, (q.size() == 0 && !bus_req)}, 32'd1);
  endtask

  initial begin
    logic [15:0] s;
    logic [12:0] d;
    int len, n;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    rst_l = 1'b0; io_we_l = 1'b1; io_re_l = 1'b1; io_oe = 1'b0; dmg = 1'b0;
    hblank = 1'b0; gnt_tied = 1'b1; io_addr = 16'h0000; io_wdata = 8'h00;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    check("reset_bus_req", {31'd0, bus_req}, 32'd0);
    check("reset_strobes", {30'd0, mem_re_l, mem_we_l}, 32'd3);
    check("reset_addr", {16'd0, mem_addr}, 32'd0);
    rst_l = 1'b1;
    io_read_check("reset_ff55", 16'hFF55, 8'hFF);
    io_read_check("read_ff51", 16'hFF51, 8'hFF);

    // Directed GDMA from WRAM, one block, grant tied high
    io_write(16'hFF51, 8'hC1); io_write(16'hFF52, 8'h2F);
    io_write(16'hFF53, 8'hE3); io_write(16'hFF54, 8'h45);
    push_blocks(16'hC120, 13'h0340, 1);
    stall_cycles = 0;
    io_write(16'hFF55, 8'h00);
    wait_done("gdma_done", 2000);
    check("gdma_stall_cycles", stall_cycles, 1 + BLK_CYC + 1);
    io_read_check("gdma_ff55", 16'hFF55, 8'hFF);

    // Randomised GDMA runs with delayed grants
    gnt_tied = 1'b0;
    for (int it = 0; it < 6; it++) begin
      s = {8'($urandom), 4'($urandom), 4'h0};
      d = {5'($urandom), 4'($urandom), 4'h0};
      len = $urandom_range(0, 2);
      gnt_delay = $urandom_range(0, 5);
      set_regs(s, d);
      push_blocks(s, d, len + 1);
      io_write(16'hFF55, 8'(len));
      wait_done("rand_gdma_done", 3000);
      io_read_check("rand_gdma_ff55", 16'hFF55, 8'hFF);
    end

    // HDMA: three blocks, one per HBlank rise
    gnt_tied = 1'b1;
    set_regs(16'h4000, 13'h0800);
    io_write(16'hFF55, 8'h82);
    io_read_check("hdma_start_ff55", 16'hFF55, 8'h02);
    repeat (10) @(negedge clk);
    check("hdma_waits_hblank", {31'd0, bus_req}, 32'd0);
    for (int b = 0; b < 3; b++) begin
      push_blocks(16'h4000 + 16'(16 * b), 13'h0800 + 13'(16 * b), 1);
      @(negedge clk); hblank = 1'b1;
      wait_done("hdma_block_done", 500);
      if (b == 0) begin
        repeat (20) @(negedge clk);
        check("hdma_no_extra_block", {31'd0, bus_req}, 32'd0);
      end
      hblank = 1'b0;
      repeat (2) @(negedge clk);
      io_read_check("hdma_len", 16'hFF55, (b == 0) ? 8'h01 : (b == 1) ? 8'h00 : 8'hFF);
    end

    // HDMA stop after one block
    set_regs(16'h1230, 13'h1560);
    io_write(16'hFF55, 8'h85);
    push_blocks(16'h1230, 13'h1560, 1);
    @(negedge clk); hblank = 1'b1;
    wait_done("stop_block_done", 500);
    hblank = 1'b0;
    io_read_check("stop_before", 16'hFF55, 8'h04);
    io_write(16'hFF55, 8'h00);
    io_read_check("stop_after", 16'hFF55, 8'h84);
    for (int p = 0; p < 2; p++) begin
      @(negedge clk); hblank = 1'b1;
      repeat (5) @(negedge clk); hblank = 1'b0;
      repeat (5) @(negedge clk);
    end
    check("stopped_no_bus", {31'd0, bus_req}, 32'd0);

    // Address wrap: src past 0xFFFF, dst past 0x9FFF
    set_regs(16'hFFF0, 13'h1FF0);
    push_blocks(16'hFFF0, 13'h1FF0, 2);
    io_write(16'hFF55, 8'h01);
    wait_done("wrap_done", 1000);
    io_read_check("wrap_ff55", 16'hFF55, 8'hFF);

    // Reset in the middle of a read
    gnt_tied = 1'b0; gnt_delay = 5;
    set_regs(16'h2000, 13'h0000);
    push_blocks(16'h2000, 13'h0000, 4);
    io_write(16'hFF55, 8'h03);
    n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (mem_re_l && n < 50);
    check("reached_read", {31'd0, mem_re_l}, 32'd0);
    rst_l = 1'b0;
    @(negedge clk); #1;
    check("midrd_reset_strobes", {30'd0, mem_re_l, mem_we_l}, 32'd3);
    check("midrd_reset_req", {30'd0, bus_req, stall}, 32'd0);
    q.delete();
    rst_l = 1'b1;
    io_read_check("midrd_reset_ff55", 16'hFF55, 8'hFF);
    repeat (10) @(negedge clk);
    check("midrd_stays_idle", {31'd0, bus_req}, 32'd0);

    // DMG mode blocks starts
    dmg = 1'b1;
    io_write(16'hFF55, 8'h00);
    repeat (20) @(negedge clk);
    check("dmg_no_req", {31'd0, bus_req}, 32'd0);
    io_read_check("dmg_ff55", 16'hFF55, 8'hFF);
    dmg = 1'b0;
    io_read_check("after_dmg_ff55", 16'hFF55, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
